// File: rtl/bpd_harness_scheduler_if.sv
// Signal bundle between front end, commit path, bpd_harness_scheduler and the DPI harness.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface bpd_harness_scheduler_if #(
  parameter int PC_W      = 64,
  parameter int UPD_DEPTH = 8
);
  localparam int CNT_W = $clog2(UPD_DEPTH) + 1;

  logic             pred_req_valid;
  logic             pred_req_ready;
  logic [PC_W-1:0]  pred_req_pc;
  logic             pred_resp_valid;
  logic [PC_W-1:0]  pred_resp_pc;
  logic             pred_resp_taken;
  logic             upd_in_valid;
  logic             upd_in_ready;
  logic [PC_W-1:0]  upd_in_pc;
  logic             upd_in_taken;
  logic [CNT_W-1:0] upd_count;
  logic             hw_req_valid;
  logic [PC_W-1:0]  hw_req_pc;
  logic             hw_req_taken;
  logic             hw_upd_valid;
  logic [PC_W-1:0]  hw_upd_pc;
  logic             hw_upd_taken;

  modport slave (
    input  pred_req_valid, pred_req_pc, upd_in_valid, upd_in_pc, upd_in_taken, hw_req_taken,
    output pred_req_ready, pred_resp_valid, pred_resp_pc, pred_resp_taken, upd_in_ready,
           upd_count, hw_req_valid, hw_req_pc, hw_upd_valid, hw_upd_pc, hw_upd_taken
  );

  modport master (
    output pred_req_valid, pred_req_pc, upd_in_valid, upd_in_pc, upd_in_taken, hw_req_taken,
    input  pred_req_ready, pred_resp_valid, pred_resp_pc, pred_resp_taken, upd_in_ready,
           upd_count, hw_req_valid, hw_req_pc, hw_upd_valid, hw_upd_pc, hw_upd_taken
  );
endinterface

// File: rtl/bpd_harness_scheduler.sv
// Single-slot scheduler in front of the DPI branch-predictor harness: predicts vs queued updates.
// Optional macro BPD_SCHED_PERF_EN adds 32-bit perf counters (pred grants, upd grants, forced cycles).
module bpd_harness_scheduler #(
  parameter int UPD_DEPTH    = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int PC_W         = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  bpd_harness_scheduler_if.slave bus
`ifdef BPD_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_pred_cnt,
  output logic [31:0]            perf_upd_cnt,
  output logic [31:0]            perf_force_cnt
`endif
);

  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } upd_entry_t;

  upd_entry_t       fifo_q [UPD_DEPTH];
  upd_entry_t       fifo_d [UPD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ST_W-1:0]  starve_q, starve_d;

  logic             hw_req_valid_q, hw_req_valid_d;
  logic [PC_W-1:0]  hw_req_pc_q, hw_req_pc_d;
  logic             hw_upd_valid_q, hw_upd_valid_d;
  upd_entry_t       hw_upd_q, hw_upd_d;
  logic             pred_resp_valid_q, pred_resp_valid_d;
  logic [PC_W-1:0]  pred_resp_pc_q, pred_resp_pc_d;

  logic full;
  logic empty;
  logic starved;
  logic upd_force;
  logic pred_grant;
  logic upd_grant;
  logic push;

  // Updates win the slot when the FIFO is full or predicts have starved a non-empty queue.
  always_comb begin
    full       = (count_q == CNT_W'(UPD_DEPTH));
    empty      = (count_q == '0);
    starved    = (starve_q == ST_W'(STARVE_LIMIT));
    upd_force  = full | (starved & ~empty);
    pred_grant = bus.pred_req_valid & ~reset & ~upd_force;
    upd_grant  = ~reset & ~pred_grant & ~empty;
    push       = bus.upd_in_valid & ~reset & ~full;
  end

  always_comb begin
    fifo_d            = fifo_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q + CNT_W'(push) - CNT_W'(upd_grant);
    starve_d          = starve_q;
    hw_req_valid_d    = pred_grant;
    hw_req_pc_d       = pred_grant ? bus.pred_req_pc : '0;
    hw_upd_valid_d    = upd_grant;
    hw_upd_d          = upd_grant ? fifo_q[rd_ptr_q] : '0;
    pred_resp_valid_d = hw_req_valid_q;
    pred_resp_pc_d    = hw_req_valid_q ? hw_req_pc_q : '0;

    // The pop reads the pre-push array, so a fresh entry cannot issue in its arrival cycle.
    if (push) begin
      fifo_d[wr_ptr_q].pc    = bus.upd_in_pc;
      fifo_d[wr_ptr_q].taken = bus.upd_in_taken;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (upd_grant) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (upd_grant || empty) begin
      starve_d = '0;
    end else if (pred_grant && !starved) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < UPD_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      starve_q          <= '0;
      hw_req_valid_q    <= 1'b0;
      hw_req_pc_q       <= '0;
      hw_upd_valid_q    <= 1'b0;
      hw_upd_q          <= '0;
      pred_resp_valid_q <= 1'b0;
      pred_resp_pc_q    <= '0;
    end else begin
      fifo_q            <= fifo_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      starve_q          <= starve_d;
      hw_req_valid_q    <= hw_req_valid_d;
      hw_req_pc_q       <= hw_req_pc_d;
      hw_upd_valid_q    <= hw_upd_valid_d;
      hw_upd_q          <= hw_upd_d;
      pred_resp_valid_q <= pred_resp_valid_d;
      pred_resp_pc_q    <= pred_resp_pc_d;
    end
  end

  assign bus.pred_req_ready  = ~reset & ~upd_force;
  assign bus.upd_in_ready    = ~reset & ~full;
  assign bus.upd_count       = count_q;
  assign bus.hw_req_valid    = hw_req_valid_q;
  assign bus.hw_req_pc       = hw_req_pc_q;
  assign bus.hw_upd_valid    = hw_upd_valid_q;
  assign bus.hw_upd_pc       = hw_upd_q.pc;
  assign bus.hw_upd_taken    = hw_upd_q.taken;
  assign bus.pred_resp_valid = pred_resp_valid_q;
  assign bus.pred_resp_pc    = pred_resp_pc_q;
  // The harness answers one cycle after the request, so its direction is taken live.
  assign bus.pred_resp_taken = pred_resp_valid_q & bus.hw_req_taken;

`ifdef BPD_SCHED_PERF_EN
  logic [31:0] perf_pred_q, perf_pred_d;
  logic [31:0] perf_upd_q, perf_upd_d;
  logic [31:0] perf_force_q, perf_force_d;

  always_comb begin
    perf_pred_d  = perf_pred_q + 32'(pred_grant);
    perf_upd_d   = perf_upd_q + 32'(upd_grant);
    perf_force_d = perf_force_q + 32'(upd_force & bus.pred_req_valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_pred_q  <= '0;
      perf_upd_q   <= '0;
      perf_force_q <= '0;
    end else begin
      perf_pred_q  <= perf_pred_d;
      perf_upd_q   <= perf_upd_d;
      perf_force_q <= perf_force_d;
    end
  end

  assign perf_pred_cnt  = perf_pred_q;
  assign perf_upd_cnt   = perf_upd_q;
  assign perf_force_cnt = perf_force_q;
`endif

endmodule
